// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit : program-counter stage for the RV fetch path.
//
// Picks the next fetch PC from, highest priority first: trap vector, branch/jump
// redirect, buffered (pending) redirect, or sequential increment. The PC only
// moves when the stage is running, the hazard unit is not stalling and imem
// accepts the fetch. A trap or redirect that arrives while frozen is parked in
// a one-entry pending buffer. A parked trap is never replaced by a later
// redirect.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   defined   - targets loaded with nonzero low ALIGN_BITS have those bits
//               cleared. misalign pulses for the cycle after such a load.
//   undefined - targets are loaded verbatim and misalign is tied low.
//
// Ports:
//   CLK             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   stall           in   hazard unit freezes the PC
//   imem_ready      in   imem accepts the fetch at pc_actual this cycle
//   redirect_valid  in   branch taken / jump resolved this cycle
//   redirect_target in   redirect destination
//   trap            in   exception/interrupt request (one-cycle pulse)
//   trap_vector     in   trap handler address
//   pc_actual       out  current fetch PC (registered)
//   pc_valid        out  pc_actual is a valid fetch request (registered)
//   pc_plus         out  pc_actual + INC, modulo 2^XLEN (link address)
//   misalign        out  target misalignment pulse
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc_actual,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus,
  output logic            misalign
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state_r;
  logic [0:0]      state_next_s;
  logic [XLEN-1:0] pc_r;
  logic            pc_valid_r;
  logic [XLEN-1:0] pend_target_r;
  logic            pend_valid_r;
  logic            pend_trap_r;

  logic            adv_s;
  logic            load_s;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_load_s;
  logic [XLEN-1:0] pend_target_next_s;
  logic            pend_valid_next_s;
  logic            pend_trap_next_s;

  // The increment wraps naturally at XLEN bits.
  assign pc_plus   = pc_r + XLEN'(INC);
  assign pc_actual = pc_r;
  assign pc_valid  = pc_valid_r;
  assign adv_s     = (state_r == ST_RUN) && !stall && imem_ready;

  // BOOT lasts exactly one edge after reset; RUN is sticky until reset.
  always_comb begin
    case (state_r)
      ST_BOOT: state_next_s = ST_RUN;
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_RUN;
    endcase
  end

  // Next-PC selection and pending-buffer update.
  always_comb begin
    pc_next_s          = pc_r;
    load_s             = 1'b0;
    pend_target_next_s = pend_target_r;
    pend_valid_next_s  = pend_valid_r;
    pend_trap_next_s   = pend_trap_r;
    if (adv_s) begin
      pend_valid_next_s = 1'b0;
      pend_trap_next_s  = 1'b0;
      if (trap) begin
        pc_next_s = trap_vector;
        load_s    = 1'b1;
      end else if (redirect_valid) begin
        pc_next_s = redirect_target;
        load_s    = 1'b1;
      end else if (pend_valid_r) begin
        pc_next_s = pend_target_r;
        load_s    = 1'b1;
      end else begin
        pc_next_s = pc_plus;
      end
    end else begin
      // Frozen (stall, back-pressure or BOOT): park the request.
      // A parked trap must survive any later redirect.
      if (trap) begin
        pend_target_next_s = trap_vector;
        pend_valid_next_s  = 1'b1;
        pend_trap_next_s   = 1'b1;
      end else if (redirect_valid && !pend_trap_r) begin
        pend_target_next_s = redirect_target;
        pend_valid_next_s  = 1'b1;
      end else begin
        pend_valid_next_s  = pend_valid_r;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((ONE << ALIGN_BITS) - ONE);

  function automatic logic [XLEN-1:0] align_clear(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & ~ALIGN_MASK);
  endfunction

  logic misalign_r;
  logic misalign_next_s;

  // Alignment is judged on the value actually loaded, not at capture time.
  always_comb begin
    if (load_s) begin
      pc_load_s       = align_clear(pc_next_s);
      misalign_next_s = is_misaligned(pc_next_s);
    end else begin
      pc_load_s       = pc_next_s;
      misalign_next_s = 1'b0;
    end
  end

  // Misalignment pulse register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_next_s;
    end
  end

  assign misalign = misalign_r;
`else
  assign pc_load_s = pc_next_s;
  assign misalign  = 1'b0;
`endif

  // PC, state and pending-buffer registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_VECTOR;
      pc_valid_r    <= 1'b0;
      pend_target_r <= {XLEN{1'b0}};
      pend_valid_r  <= 1'b0;
      pend_trap_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_load_s;
      pc_valid_r    <= (state_next_s == ST_RUN);
      pend_target_r <= pend_target_next_s;
      pend_valid_r  <= pend_valid_next_s;
      pend_trap_r   <= pend_trap_next_s;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit : scoreboard bench for pc_unit (XLEN=32, RESET_VECTOR=0, INC=4).
// The driver issues one cycle of stimulus and queues the hand-computed state
// expected right after the next clock edge (or right after an async reset
// assertion). The monitor pops and compares on each of those events.
// ---------------------------------------------------------------------------
module tb_pc_unit;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        trap = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic [31:0] pc_actual;
  logic        pc_valid;
  logic [31:0] pc_plus;
  logic        misalign;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_unit dut (
    .CLK(CLK), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap(trap), .trap_vector(trap_vector),
    .pc_actual(pc_actual), .pc_valid(pc_valid), .pc_plus(pc_plus),
    .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  // Monitor: compare after every clock edge and every reset assertion.
  always @(posedge CLK or posedge reset) begin
    exp_t        e;
    logic [31:0] want_plus;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      want_plus = e.pc + 32'd4;
      checks = checks + 4;
      if (pc_actual !== e.pc) begin
        errors++;
        $display("FAIL %s pc_actual got %h want %h", e.name, pc_actual, e.pc);
      end
      if (pc_plus !== want_plus) begin
        errors++;
        $display("FAIL %s pc_plus got %h want %h", e.name, pc_plus, want_plus);
      end
      if (pc_valid !== e.valid) begin
        errors++;
        $display("FAIL %s pc_valid got %b want %b", e.name, pc_valid, e.valid);
      end
      if (misalign !== e.mis) begin
        errors++;
        $display("FAIL %s misalign got %b want %b", e.name, misalign, e.mis);
      end
    end
  end

  task automatic expect_push(input string name, input logic [31:0] pc,
                             input logic v, input logic m);
    exp_t e;
    e.name = name; e.pc = pc; e.valid = v; e.mis = m;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus plus the expectation after its edge.
  task automatic step(input string name, input logic st, input logic rdy,
                      input logic rv, input logic [31:0] rt,
                      input logic tr, input logic [31:0] tv,
                      input logic [31:0] exp_pc, input logic exp_v,
                      input logic exp_m);
    stall = st; imem_ready = rdy;
    redirect_valid = rv; redirect_target = rt;
    trap = tr; trap_vector = tv;
    expect_push(name, exp_pc, exp_v, exp_m);
    @(posedge CLK);
    #2;
  endtask

  // Global time bound.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // 1. Async reset, one BOOT cycle, then sequential fetch.
    #1;
    expect_push("reset_async", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step("reset_hold", 0, 1, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step("boot_exit",  0, 1, 0, 0, 0, 0, 32'h0,  1'b1, 1'b0);
    step("seq_4",      0, 1, 0, 0, 0, 0, 32'h4,  1'b1, 1'b0);
    step("seq_8",      0, 1, 0, 0, 0, 0, 32'h8,  1'b1, 1'b0);
    step("seq_c",      0, 1, 0, 0, 0, 0, 32'hC,  1'b1, 1'b0);
    step("seq_10",     0, 1, 0, 0, 0, 0, 32'h10, 1'b1, 1'b0);
    // 2. Redirect with advance: one-cycle latency.
    step("redir_100",  0, 1, 1, 32'h100, 0, 0, 32'h100, 1'b1, 1'b0);
    step("seq_104",    0, 1, 0, 0, 0, 0, 32'h104, 1'b1, 1'b0);
    step("redir_20",   0, 1, 1, 32'h20, 0, 0, 32'h20, 1'b1, 1'b0);
    // 3. Redirects during stall: latest wins.
    step("stall_r200", 1, 1, 1, 32'h200, 0, 0, 32'h20, 1'b1, 1'b0);
    step("stall_r300", 1, 1, 1, 32'h300, 0, 0, 32'h20, 1'b1, 1'b0);
    step("stall_idle", 1, 1, 0, 0, 0, 0, 32'h20, 1'b1, 1'b0);
    step("pend_300",   0, 1, 0, 0, 0, 0, 32'h300, 1'b1, 1'b0);
    step("seq_304",    0, 1, 0, 0, 0, 0, 32'h304, 1'b1, 1'b0);
    // 4. Pending trap kept over later redirect; trap beats redirect.
    step("stall_trap", 1, 1, 0, 0, 1, 32'h80, 32'h304, 1'b1, 1'b0);
    step("stall_r400", 1, 1, 1, 32'h400, 0, 0, 32'h304, 1'b1, 1'b0);
    step("pend_trap",  0, 1, 0, 0, 0, 0, 32'h80, 1'b1, 1'b0);
    step("trap_win",   0, 1, 1, 32'h500, 1, 32'h180, 32'h180, 1'b1, 1'b0);
    step("seq_184",    0, 1, 0, 0, 0, 0, 32'h184, 1'b1, 1'b0);
    step("stall_both", 1, 1, 1, 32'h600, 1, 32'h240, 32'h184, 1'b1, 1'b0);
    step("pend_both",  0, 1, 0, 0, 0, 0, 32'h240, 1'b1, 1'b0);
    // Live redirect beats pending, and the pending entry is consumed.
    step("stall_r700", 1, 1, 1, 32'h700, 0, 0, 32'h240, 1'b1, 1'b0);
    step("live_r800",  0, 1, 1, 32'h800, 0, 0, 32'h800, 1'b1, 1'b0);
    step("pend_clr",   0, 1, 0, 0, 0, 0, 32'h804, 1'b1, 1'b0);
    // 5. Wraparound and imem back-pressure.
    step("redir_ff8",  0, 1, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 1'b1, 1'b0);
    step("seq_ffc",    0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step("wrap_0",     0, 1, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0);
    step("bp_1",       0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0);
    step("bp_2",       0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0);
    step("bp_3",       0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0);
    step("bp_done",    0, 1, 0, 0, 0, 0, 32'h4, 1'b1, 1'b0);
    // 6. Misaligned targets: direct redirect, pending redirect, trap.
    step("mis_r102",   0, 1, 1, 32'h102, 0, 0, ACHK ? 32'h100 : 32'h102, 1'b1, ACHK);
    step("mis_after",  0, 1, 0, 0, 0, 0, ACHK ? 32'h104 : 32'h106, 1'b1, 1'b0);
    step("mis_stall",  1, 1, 1, 32'h2FE, 0, 0, ACHK ? 32'h104 : 32'h106, 1'b1, 1'b0);
    step("mis_pend",   0, 1, 0, 0, 0, 0, ACHK ? 32'h2FC : 32'h2FE, 1'b1, ACHK);
    step("mis_trap",   0, 1, 0, 0, 1, 32'h333, ACHK ? 32'h330 : 32'h333, 1'b1, ACHK);
    step("mis_clear",  0, 1, 0, 0, 0, 0, ACHK ? 32'h334 : 32'h337, 1'b1, 1'b0);
    // Reset mid-cycle with a pending redirect: pending is lost.
    step("rst_pend",   1, 1, 1, 32'h900, 0, 0, ACHK ? 32'h334 : 32'h337, 1'b1, 1'b0);
    expect_push("rst_mid", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    step("rst_hold2",  0, 1, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    // Redirect during BOOT is captured and applied on the first RUN advance.
    step("boot_cap",   0, 1, 1, 32'hA00, 0, 0, 32'h0, 1'b1, 1'b0);
    step("boot_apply", 0, 1, 0, 0, 0, 0, 32'hA00, 1'b1, 1'b0);
    step("seq_a04",    0, 1, 0, 0, 0, 0, 32'hA04, 1'b1, 1'b0);

    #10;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
